dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Sits directly upstream of the data-memory BRAM, between the commit-side store path / load unit and the single-port dmem.
- Queues committed stores in a small FIFO and drains them into dmem in order, one per idle memory cycle.
- Arbitrates the single dmem port between loads and drains. Forwards buffered store data to loads so that program order is preserved.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- DEPTH_LOG, 2, log2(DEPTH); sizes the pointers; the count is DEPTH_LOG+1 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  committed store offered
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  ADDR_LEN  store word address
- st_data  in  DATA_LEN  store data
- ld_valid  in  1  load request
- ld_ready  out  1  load accepted this cycle
- ld_addr  in  ADDR_LEN  load word address
- ld_rvalid  out  1  load data valid (one cycle after acceptance)
- ld_rdata  out  DATA_LEN  load result
- mem_addr  out  ADDR_LEN  to dmem addr
- mem_wdata  out  DATA_LEN  to dmem wdata
- mem_we  out  1  to dmem we
- mem_rdata  in  DATA_LEN  from dmem rdata (1-cycle latency)
- sb_empty  out  1  no buffered stores; used by fence/halt logic
- sb_count  out  DEPTH_LOG+1  occupied entries

Behaviour:
- Reset (synchronous, high, sampled at posedge clk):
  - head, tail and count go to 0.
  - ld_rvalid=0, ld_rdata=0, mem_we=0, sb_empty=1, sb_count=0.
  - Entry contents are don't-care. Reset asserted mid-drain discards all buffered stores.
- Address match:
  - Compare only ld_addr[DMEM_SIZE_LOG-1:0] against the stored address bits, which is exactly the index dmem uses.
  - Aliasing addresses therefore forward correctly.
- Store push: occurs when st_valid && st_ready; writes entry[tail] and increments tail (wraps mod DEPTH). st_ready = (count != DEPTH), combinational from registered state only.
- Port arbitration, evaluated each cycle with combinational mem_* outputs:
  - Full (count==DEPTH): the drain has priority and ld_ready=0.
  - Otherwise, if ld_valid: ld_ready=1, mem_addr=ld_addr, mem_we=0.
  - Otherwise, if count!=0: drain entry[head] with mem_addr=entry.addr, mem_wdata=entry.data, mem_we=1; head++ (wraps).
  - Otherwise: mem_we=0 and mem_addr=ld_addr.
- Simultaneous push and drain: count is unchanged. Push while full is impossible because st_ready=0. A store refused while full may be accepted the next cycle after the drain.
- Forwarding, on load acceptance:
  - Search all valid entries plus the store being pushed in the same cycle.
  - Youngest match wins: the same-cycle push is youngest, then entries from tail-1 back to head.
  - The hit flag and data are registered. On the next cycle: ld_rvalid=1 and ld_rdata = hit ? fwd_data : mem_rdata.
  - Load latency is always exactly 1 cycle.
- An entry drained in the same cycle a load is accepted does not occur, because a load and a drain never share a cycle.
- sb_empty = (count==0). Both sb_empty and sb_count reflect registered state.
- Full-word accesses only; no byte enables.

Decomposition:
- ADDR_LEN, DATA_LEN, DMEM_SIZE_LOG come from the shared constants.vh; no new global constants.
- One sub-module, sb_fwd_match: combinational youngest-match priority search over DEPTH entries, taking head/count as age reference.
- FIFO storage, pointers and arbitration stay in the top module.

Test Plan:
- Reset then idle: sb_empty=1, ld_rvalid=0, mem_we=0 for 5 cycles.
- Push 0x10<-0xAAAA with no loads:
  - Next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xAAAA; then sb_empty=1.
  - A later load of 0x10 returns 0xAAAA from dmem.
- Push four stores while a load is issued every cycle:
  - Buffer fills to count=4; st_ready=0 and ld_ready=0.
  - A drain occurs; the refused store is accepted the next cycle.
- Push 0x20<-1 then 0x20<-2 while loads block draining; load 0x20:
  - ld_rvalid one cycle later with ld_rdata=2 (youngest entry).
- Same-cycle push 0x30<-0x55 and load 0x30: ld_rdata=0x55 next cycle.
- Assert reset with 3 entries buffered: next cycle count=0, mem_we=0, and no further writes to dmem.

Source files
------------

// File: rtl/dmem_store_buffer_pkg.sv
// Shared types and constants for the data-memory store buffer.
// Latency: n/a (types, constants and one index helper only).
// Backpressure: n/a.
package dmem_store_buffer_pkg;

    // Global dmem geometry (word address width, data width, dmem index width).
    localparam int ADDR_LEN      = 16;
    localparam int DATA_LEN      = 32;
    localparam int DMEM_SIZE_LOG = 8;

    typedef logic [ADDR_LEN-1:0]      addr_t;
    typedef logic [DATA_LEN-1:0]      data_t;
    typedef logic [DMEM_SIZE_LOG-1:0] dmem_idx_t;

    // One buffered committed store.
    typedef struct packed {
        addr_t addr;
        data_t data;
    } sb_entry_t;

    // Owner of the single dmem port in a given cycle.
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_LOAD  = 2'd1,
        GNT_DRAIN = 2'd2
    } port_gnt_e;

    // The bits dmem actually decodes; addresses equal here alias to one word.
    function automatic dmem_idx_t dmem_idx(input addr_t a);
        return a[DMEM_SIZE_LOG-1:0];
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search of buffered stores (plus the same-cycle push) for a load address.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only on load acceptance.
// Ports: entries_i/head_i/count_i describe the FIFO contents in age order,
//        push_i/push_entry_i the store entering this cycle, ld_addr_i the load,
//        hit_o/data_o the forwarding result.
module sb_fwd_match
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic [DEPTH_LOG-1:0]  head_i,
    input  logic [DEPTH_LOG:0]    count_i,
    input  logic                  push_i,
    input  sb_entry_t             push_entry_i,
    input  addr_t                 ld_addr_i,
    output logic                  hit_o,
    output data_t                 data_o
);

    localparam int CW = DEPTH_LOG + 1;

    always_comb begin
        logic [DEPTH_LOG-1:0] idx;
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        // Walk from oldest (head) to youngest; each later match overrides,
        // so the survivor is the youngest buffered match.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + DEPTH_LOG'(i);
            if ((CW'(i) < count_i) &&
                (dmem_idx(entries_i[idx].addr) == dmem_idx(ld_addr_i))) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
        // The store being pushed this cycle is younger than anything buffered.
        if (push_i && (dmem_idx(push_entry_i.addr) == dmem_idx(ld_addr_i))) begin
            hit_o  = 1'b1;
            data_o = push_entry_i.data;
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer in front of the single-port dmem: queues committed stores, drains them in
// order on idle cycles, arbitrates loads vs drains and forwards buffered data to loads.
// Latency: loads return exactly 1 cycle after acceptance; stores drain >=1 cycle after push.
// Backpressure: st_ready_o/ld_ready_o both drop when the buffer is full (drain forced).
// Ports: st_* committed store in, ld_* load request/response, mem_* dmem port,
//        sb_empty_o/sb_count_o registered occupancy for fence/halt logic.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [ADDR_LEN-1:0] st_addr_i,
    input  logic [DATA_LEN-1:0] st_data_i,
    input  logic                ld_valid_i,
    output logic                ld_ready_o,
    input  logic [ADDR_LEN-1:0] ld_addr_i,
    output logic                ld_rvalid_o,
    output logic [DATA_LEN-1:0] ld_rdata_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic                mem_we_o,
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    output logic                sb_empty_o,
    output logic [DEPTH_LOG:0]  sb_count_o
);

    localparam int CW = DEPTH_LOG + 1;

    sb_entry_t [DEPTH-1:0] entries_q;
    logic [DEPTH_LOG-1:0]  head_q, head_d;
    logic [DEPTH_LOG-1:0]  tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ld_rvalid_q, ld_rvalid_d;
    logic                  fwd_hit_q, fwd_hit_d;
    data_t                 fwd_data_q, fwd_data_d;

    logic      full, empty, push, drain, ld_accept;
    port_gnt_e gnt;
    sb_entry_t push_entry, head_entry;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign st_ready_o = !full;
    assign ld_ready_o = !full;
    assign push       = st_valid_i && st_ready_o;
    assign ld_accept  = ld_valid_i && ld_ready_o;
    assign push_entry = '{addr: st_addr_i, data: st_data_i};
    assign head_entry = entries_q[head_q];

    // Port arbitration. A full buffer forces a drain so stores can never deadlock
    // behind a steady load stream; otherwise loads win. The drain is suppressed
    // while reset is asserted so discarded stores never reach dmem.
    always_comb begin
        gnt = GNT_IDLE;
        if (reset_i) begin
            gnt = GNT_IDLE;
        end else if (full) begin
            gnt = GNT_DRAIN;
        end else if (ld_valid_i) begin
            gnt = GNT_LOAD;
        end else if (!empty) begin
            gnt = GNT_DRAIN;
        end
    end

    assign drain = (gnt == GNT_DRAIN);

    always_comb begin
        mem_addr_o  = ld_addr_i;
        mem_wdata_o = head_entry.data;
        mem_we_o    = 1'b0;
        if (drain) begin
            mem_addr_o = head_entry.addr;
            mem_we_o   = 1'b1;
        end
    end

    sb_fwd_match #(
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fwd (
        .entries_i    (entries_q),
        .head_i       (head_q),
        .count_i      (count_q),
        .push_i       (push),
        .push_entry_i (push_entry),
        .ld_addr_i    (ld_addr_i),
        .hit_o        (fwd_hit_d),
        .data_o       (fwd_data_d)
    );

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        ld_rvalid_d = ld_accept;
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry payload needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries_q[tail_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ld_rvalid_q <= 1'b0;
            fwd_hit_q   <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ld_rvalid_q <= ld_rvalid_d;
            fwd_hit_q   <= fwd_hit_d && ld_accept;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // dmem read data arrives one cycle after the load address was presented,
    // lining up with the registered forwarding decision.
    always_comb begin
        ld_rdata_o = '0;
        if (ld_rvalid_q) begin
            ld_rdata_o = fwd_hit_q ? fwd_data_q : mem_rdata_i;
        end
    end

    assign ld_rvalid_o = ld_rvalid_q;
    assign sb_empty_o  = empty;
    assign sb_count_o  = count_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized scoreboard bench for dmem_store_buffer with a program-order memory model.
// Latency: n/a.
// Backpressure: stores refused by st_ready_o are re-offered until accepted.
module tb_dmem_store_buffer;
    import dmem_store_buffer_pkg::*;

    localparam int DEPTH     = 4;
    localparam int DEPTH_LOG = 2;
    localparam int MEM_WORDS = 1 << DMEM_SIZE_LOG;

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b1;
    logic                st_valid_i = 1'b0;
    logic                st_ready_o;
    logic [ADDR_LEN-1:0] st_addr_i = '0;
    logic [DATA_LEN-1:0] st_data_i = '0;
    logic                ld_valid_i = 1'b0;
    logic                ld_ready_o;
    logic [ADDR_LEN-1:0] ld_addr_i = '0;
    logic                ld_rvalid_o;
    logic [DATA_LEN-1:0] ld_rdata_o;
    logic [ADDR_LEN-1:0] mem_addr_o;
    logic [DATA_LEN-1:0] mem_wdata_o;
    logic                mem_we_o;
    logic [DATA_LEN-1:0] mem_rdata_i = '0;
    logic                sb_empty_o;
    logic [DEPTH_LOG:0]  sb_count_o;

    dmem_store_buffer #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .st_valid_i  (st_valid_i),
        .st_ready_o  (st_ready_o),
        .st_addr_i   (st_addr_i),
        .st_data_i   (st_data_i),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_addr_i   (ld_addr_i),
        .ld_rvalid_o (ld_rvalid_o),
        .ld_rdata_o  (ld_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_rdata_i (mem_rdata_i),
        .sb_empty_o  (sb_empty_o),
        .sb_count_o  (sb_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Physical dmem: synchronous write, 1-cycle read latency.
    data_t tb_mem [MEM_WORDS];
    always @(posedge clk_i) begin
        if (mem_we_o) tb_mem[dmem_idx(mem_addr_o)] <= mem_wdata_o;
        mem_rdata_i <= tb_mem[dmem_idx(mem_addr_o)];
    end

    // Reference model: memory as the program sees it (every accepted store applied
    // immediately), the FIFO of stores still owed to dmem, and the occupancy.
    data_t     arch_mem [MEM_WORDS];
    sb_entry_t exp_st[$];
    data_t     exp_ld[$];
    int        model_cnt = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic addr_t raddr();
        addr_t a;
        a = addr_t'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = a | 16'h0100;  // alias in dmem index space
        return a;
    endfunction

    // One clock cycle of stimulus: drive at negedge, check combinational/registered
    // outputs against the model, then account for what the cycle accepted.
    task automatic step(input logic sv, input addr_t sa, input data_t sd,
                        input logic lv, input addr_t la, output logic st_acc);
        logic exp_full, exp_drain, ld_acc;
        @(negedge clk_i);
        st_valid_i = sv;
        st_addr_i  = sa;
        st_data_i  = sd;
        ld_valid_i = lv;
        ld_addr_i  = la;
        #1;
        exp_full  = (model_cnt == DEPTH);
        exp_drain = exp_full || (!lv && model_cnt != 0);
        chk("st_ready", 64'(st_ready_o), 64'(!exp_full));
        chk("ld_ready", 64'(ld_ready_o), 64'(!exp_full));
        chk("mem_we", 64'(mem_we_o), 64'(exp_drain));
        chk("sb_count", 64'(sb_count_o), 64'(model_cnt));
        chk("sb_empty", 64'(sb_empty_o), 64'(model_cnt == 0));
        if (lv && !exp_full) chk("ld_mem_addr", 64'(mem_addr_o), 64'(la));
        #2;
        st_acc = sv && !exp_full;
        ld_acc = lv && !exp_full;
        if (st_acc) begin
            arch_mem[dmem_idx(sa)] = sd;
            exp_st.push_back('{addr: sa, data: sd});
        end
        if (ld_acc) exp_ld.push_back(arch_mem[dmem_idx(la)]);
        model_cnt = model_cnt + (st_acc ? 1 : 0) - (exp_drain ? 1 : 0);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, acc);
    endtask

    // Offer a store until accepted (bounded), with an optional load each cycle.
    task automatic store_retry(input addr_t sa, input data_t sd, input logic lv, input addr_t la);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 10) begin
            step(1'b1, sa, sd, lv, la, acc);
            tries++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL store_accept_timeout: store %0h never accepted", sa);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i    = 1'b1;
        st_valid_i = 1'b0;
        ld_valid_i = 1'b0;
        #1;
        chk("reset_mem_we", 64'(mem_we_o), 64'd0);
        #2;
        model_cnt = 0;
        exp_st.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("post_reset_count", 64'(sb_count_o), 64'd0);
        chk("post_reset_empty", 64'(sb_empty_o), 64'd1);
        chk("post_reset_rvalid", 64'(ld_rvalid_o), 64'd0);
        chk("post_reset_rdata", 64'(ld_rdata_o), 64'd0);
        chk("post_reset_mem_we", 64'(mem_we_o), 64'd0);
        foreach (tb_mem[i]) arch_mem[i] = tb_mem[i];
        reset_i = 1'b1;  // held for the remainder of this cycle, released by the caller
    endtask

    // Monitor: pops the scoreboards whenever the DUT writes dmem or returns a load.
    initial begin
        sb_entry_t e;
        data_t     d;
        forever begin
            @(negedge clk_i);
            #2;
            if (mem_we_o) begin
                if (exp_st.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL drain_unexpected: addr %0h data %0h", mem_addr_o, mem_wdata_o);
                end else begin
                    e = exp_st.pop_front();
                    chk("drain_addr", 64'(mem_addr_o), 64'(e.addr));
                    chk("drain_data", 64'(mem_wdata_o), 64'(e.data));
                end
            end
            if (ld_rvalid_o || exp_ld.size() != 0) begin
                chk("ld_rvalid", 64'(ld_rvalid_o), 64'(exp_ld.size() != 0));
                if (exp_ld.size() != 0) begin
                    d = exp_ld.pop_front();
                    if (ld_rvalid_o) chk("ld_rdata", 64'(ld_rdata_o), 64'(d));
                end
            end
        end
    end

    initial begin
        logic  acc;
        logic  pend;
        addr_t pa;
        data_t pd;
        logic  lv;

        foreach (arch_mem[i]) arch_mem[i] = '0;
        do_reset();
        do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;

        // Idle after reset.
        idle(5);

        // Single store drains on the next idle cycle, then reads back from dmem.
        step(1'b1, 16'h0010, 32'h0000_AAAA, 1'b0, '0, acc);
        idle(3);
        step(1'b0, '0, '0, 1'b1, 16'h0010, acc);
        idle(2);

        // Continuous loads block draining: buffer fills, drain forced, refused store retried.
        for (int k = 0; k < 6; k++) store_retry(addr_t'(16'h0040 + k), data_t'(32'h100 + k), 1'b1, 16'h0050);
        idle(8);

        // Two stores to one address; youngest must be forwarded.
        store_retry(16'h0020, 32'd1, 1'b1, 16'h0021);
        store_retry(16'h0020, 32'd2, 1'b1, 16'h0021);
        step(1'b0, '0, '0, 1'b1, 16'h0020, acc);
        idle(5);

        // Same-cycle push and load of the same address.
        step(1'b1, 16'h0030, 32'h55, 1'b1, 16'h0030, acc);
        idle(5);

        // Aliasing: store via one alias, load via another.
        store_retry(16'h0105, 32'hBEEF, 1'b1, 16'h0006);
        step(1'b0, '0, '0, 1'b1, 16'h0005, acc);
        idle(5);

        // Reset with three entries buffered: they must never reach dmem.
        store_retry(16'h0060, 32'h6001, 1'b1, 16'h0000);
        store_retry(16'h0061, 32'h6002, 1'b1, 16'h0000);
        store_retry(16'h0062, 32'h6003, 1'b1, 16'h0000);
        do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        idle(6);
        step(1'b0, '0, '0, 1'b1, 16'h0060, acc);
        idle(2);

        // Randomized traffic with retried stores.
        pend = 1'b0;
        pa = '0;
        pd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend && $urandom_range(0, 99) < 55) begin
                pend = 1'b1;
                pa = raddr();
                pd = $urandom;
            end
            lv = ($urandom_range(0, 99) < 60);
            step(pend, pa, pd, lv, raddr(), acc);
            if (acc) pend = 1'b0;
        end
        idle(10);

        chk("final_st_queue_empty", 64'(exp_st.size()), 64'd0);
        chk("final_sb_empty", 64'(sb_empty_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
